// File: rtl/tick_timer_pkg.sv
// Shared types and default constants for the tick timer bank.
//   ch_state_e    : per-channel FSM state (IDLE, RUN)
//   DEF_BASE_DIV  : clock cycles per base period (one second at 25 MHz)
//   DEF_TURBO_DIV : base-rate speed-up factor in turbo mode
//   DEF_CNT_W     : width of a channel period, in base ticks
package tick_timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_e;

   localparam int DEF_BASE_DIV  = 25_000_000;
   localparam int DEF_TURBO_DIV = 10;
   localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/tick_channel.sv
// One timer channel: counts base ticks up to a latched period and pulses tick.
//   clk, resetN   : clock, async active-low reset
//   base_tick     : shared one-cycle base period strobe
//   start / stop  : one-cycle start/restart and abort requests (stop wins)
//   oneshot       : mode, 1 = one-shot, 0 = periodic (latched on start)
//   period        : terminal count in base ticks (latched on start, 0 = ignore)
//   tick          : one-cycle expiry pulse
//   busy          : high while in RUN
//
// state | meaning
// IDLE  | channel stopped, count held at 0, waiting for start
// RUN   | counting base ticks toward the latched period
module tick_channel
   import tick_timer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             base_tick,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic [CNT_W-1:0] period,
   output logic             tick,
   output logic             busy
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic             mode_q, mode_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] cnt_inc;

   // per_q is never 0 in RUN, so cnt_q < per_q and the increment cannot wrap.
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      mode_d  = mode_q;
      tick_d  = 1'b0;
      if (stop) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (start) begin
         // A start takes priority over a coincident base tick, so that tick is not counted.
         cnt_d = '0;
         if (period != '0) begin
            state_d = RUN;
            per_d   = period;
            mode_d  = oneshot;
         end else begin
            state_d = IDLE;
         end
      end else if (state_q == RUN && base_tick) begin
         if (cnt_inc == per_q) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            if (mode_q) begin
               state_d = IDLE;
            end
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         mode_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         mode_q  <= mode_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;
   assign busy = (state_q == RUN);

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of NUM_CH independent tick timers sharing one base-period prescaler.
//   clk, resetN : clock, async active-low reset
//   turbo       : selects the shortened base period BASE_DIV/TURBO_DIV
//   start, stop : per-channel one-cycle start/restart and abort requests
//   oneshot     : per-channel mode, 1 = one-shot, 0 = periodic
//   period      : per-channel terminal count, channel i at [i*CNT_W +: CNT_W]
//   base_tick   : one-cycle pulse once per base period
//   tick        : per-channel one-cycle expiry pulse
//   busy        : per-channel RUN indicator
module tick_timer_bank
   import tick_timer_pkg::*;
#(
   parameter int BASE_DIV  = DEF_BASE_DIV,
   parameter int TURBO_DIV = DEF_TURBO_DIV,
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    turbo,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH-1:0]       oneshot,
   input  logic [NUM_CH*CNT_W-1:0] period,
   output logic                    base_tick,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       busy
);

   // Both limits are resolved at elaboration; the turbo period is clamped to at least one cycle.
   localparam int TURBO_PERIOD = (BASE_DIV / TURBO_DIV > 0) ? BASE_DIV / TURBO_DIV : 1;
   localparam int PS_W         = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam logic [PS_W-1:0] LIMIT_NORM  = PS_W'(BASE_DIV - 1);
   localparam logic [PS_W-1:0] LIMIT_TURBO = PS_W'(TURBO_PERIOD - 1);

   logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
   logic            base_tick_q, base_tick_d;
   logic [PS_W-1:0] limit;

   always_comb begin
      limit       = turbo ? LIMIT_TURBO : LIMIT_NORM;
      ps_cnt_d    = ps_cnt_q + PS_W'(1);
      base_tick_d = 1'b0;
      // >= rather than == so a turbo switch past the new limit wraps immediately.
      if (ps_cnt_q >= limit) begin
         ps_cnt_d    = '0;
         base_tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ps_cnt_q    <= '0;
         base_tick_q <= 1'b0;
      end else begin
         ps_cnt_q    <= ps_cnt_d;
         base_tick_q <= base_tick_d;
      end
   end

   assign base_tick = base_tick_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tick_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .resetN    (resetN),
         .base_tick (base_tick_q),
         .start     (start[g]),
         .stop      (stop[g]),
         .oneshot   (oneshot[g]),
         .period    (period[g*CNT_W +: CNT_W]),
         .tick      (tick[g]),
         .busy      (busy[g])
      );
   end

endmodule

// File: tb/tb_tick_timer_bank.sv
module tb_tick_timer_bank;

   localparam int BASE_DIV  = 20;
   localparam int TURBO_DIV = 10;
   localparam int NUM_CH    = 4;
   localparam int CNT_W     = 8;

   logic                    clk;
   logic                    resetN;
   logic                    turbo;
   logic [NUM_CH-1:0]       start;
   logic [NUM_CH-1:0]       stop;
   logic [NUM_CH-1:0]       oneshot;
   logic [NUM_CH*CNT_W-1:0] period;
   logic                    base_tick;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n;

   tick_timer_bank #(
      .BASE_DIV  (BASE_DIV),
      .TURBO_DIV (TURBO_DIV),
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .turbo     (turbo),
      .start     (start),
      .stop      (stop),
      .oneshot   (oneshot),
      .period    (period),
      .base_tick (base_tick),
      .tick      (tick),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   // sel 0..NUM_CH-1 watches tick[sel], sel == NUM_CH watches base_tick.
   // Returns the number of steps until the pulse is seen, or -1 on timeout.
   task automatic wait_sig(input int sel, input int max, output int cnt);
      logic hit;
      cnt = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         hit = (sel == NUM_CH) ? base_tick : tick[sel];
         if (hit && cnt < 0) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic set_period(input int ch, input int val);
      period[ch*CNT_W +: CNT_W] = CNT_W'(val);
   endtask

   initial begin
      resetN  = 1'b0;
      turbo   = 1'b0;
      start   = '0;
      stop    = '0;
      oneshot = '0;
      period  = '0;

      steps(3);
      chk("rst_base_tick", int'(base_tick), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_busy", int'(busy), 0);

      resetN = 1'b1;
      wait_sig(NUM_CH, 40, n);
      chk("first_base_tick", n, 20);
      wait_sig(NUM_CH, 40, n);
      chk("base_spacing", n, 20);

      turbo = 1'b1;
      wait_sig(NUM_CH, 40, n);
      chk("turbo_spacing_a", n, 2);
      wait_sig(NUM_CH, 40, n);
      chk("turbo_spacing_b", n, 2);
      turbo = 1'b0;
      wait_sig(NUM_CH, 40, n);
      chk("normal_after_turbo", n, 20);
      steps(15);
      turbo = 1'b1;
      wait_sig(NUM_CH, 40, n);
      chk("turbo_at_15_wrap", n, 1);
      turbo = 1'b0;
      wait_sig(NUM_CH, 40, n);
      chk("spacing_after_wrap", n, 20);

      // ch0 periodic, period 3, started on a base_tick cycle
      set_period(0, 3);
      oneshot[0] = 1'b0;
      start[0]   = 1'b1;
      step();
      start[0] = 1'b0;
      chk("ch0_busy", int'(busy[0]), 1);
      wait_sig(0, 100, n);
      chk("ch0_first_tick", n, 60);
      wait_sig(0, 100, n);
      chk("ch0_tick_spacing", n, 60);
      chk("ch0_busy_after_tick", int'(busy[0]), 1);

      // ch1 one-shot, period 2, started one cycle after a base_tick
      wait_sig(NUM_CH, 40, n);
      step();
      set_period(1, 2);
      oneshot[1] = 1'b1;
      start[1]   = 1'b1;
      step();
      start[1] = 1'b0;
      chk("ch1_busy", int'(busy[1]), 1);
      wait_sig(1, 100, n);
      chk("ch1_oneshot_tick", n, 39);
      chk("ch1_busy_drops_with_tick", int'(busy[1]), 0);
      wait_sig(1, 120, n);
      chk("ch1_no_second_tick", n, -1);

      // ch2 stopped on the cycle whose base_tick would expire it
      wait_sig(NUM_CH, 40, n);
      step();
      set_period(2, 1);
      oneshot[2] = 1'b0;
      start[2]   = 1'b1;
      step();
      start[2] = 1'b0;
      chk("ch2_busy", int'(busy[2]), 1);
      steps(18);
      chk("ch2_base_tick_present", int'(base_tick), 1);
      stop[2] = 1'b1;
      step();
      stop[2] = 1'b0;
      chk("ch2_tick_suppressed", int'(tick[2]), 0);
      chk("ch2_busy_after_stop", int'(busy[2]), 0);
      wait_sig(2, 60, n);
      chk("ch2_no_tick_after_stop", n, -1);
      start[2] = 1'b1;
      stop[2]  = 1'b1;
      step();
      start[2] = 1'b0;
      stop[2]  = 1'b0;
      chk("ch2_start_stop_idle", int'(busy[2]), 0);

      // ch3 zero period ignored, then restart mid-RUN with a new period
      set_period(3, 0);
      oneshot[3] = 1'b0;
      start[3]   = 1'b1;
      step();
      start[3] = 1'b0;
      chk("ch3_period0_idle", int'(busy[3]), 0);
      wait_sig(NUM_CH, 40, n);
      step();
      set_period(3, 3);
      start[3] = 1'b1;
      step();
      start[3] = 1'b0;
      chk("ch3_busy", int'(busy[3]), 1);
      steps(29);
      set_period(3, 5);
      start[3] = 1'b1;
      step();
      start[3] = 1'b0;
      set_period(3, 7);
      wait_sig(3, 200, n);
      chk("ch3_restart_tick", n, 89);
      wait_sig(3, 200, n);
      chk("ch3_latched_period", n, 100);

      // all channels expiring together
      stop = '1;
      step();
      stop = '0;
      chk("all_stopped", int'(busy), 0);
      wait_sig(NUM_CH, 40, n);
      step();
      for (int c = 0; c < NUM_CH; c++) set_period(c, 1);
      oneshot = '0;
      start   = '1;
      step();
      start = '0;
      chk("all_busy", int'(busy), 15);
      wait_sig(0, 40, n);
      chk("all_tick_latency", n, 19);
      chk("all_tick_together", int'(tick), 15);

      // asynchronous reset while every channel runs
      steps(5);
      #3;
      resetN = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_tick", int'(tick), 0);
      chk("async_rst_base_tick", int'(base_tick), 0);
      step();
      resetN = 1'b1;
      wait_sig(NUM_CH, 40, n);
      chk("post_rst_base_tick", n, 20);
      chk("post_rst_busy", int'(busy), 0);
      wait_sig(0, 80, n);
      chk("post_rst_no_tick", n, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tick_timer_bank.md
TICK_TIMER_BANK -- requirements
Module: tick_timer_bank

Interface
REQ-001 The block SHALL have parameter BASE_DIV, default 25_000_000, giving the clock cycles per base period (one second on DE10).
REQ-002 The block SHALL have parameter TURBO_DIV, default 10, giving the base-rate speed-up factor when turbo is high.
REQ-003 The block SHALL have parameter NUM_CH, default 4, giving the number of independent timer channels.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of each channel period in base ticks.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on posedge clk.
REQ-006 Port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port turbo, input, 1 bit: when high, the base period SHALL be BASE_DIV/TURBO_DIV cycles.
REQ-008 Port start, input, NUM_CH bits: per-channel one-cycle start/restart request.
REQ-009 Port stop, input, NUM_CH bits: per-channel one-cycle abort request.
REQ-010 Port oneshot, input, NUM_CH bits: per-channel mode; 1 = one-shot, 0 = periodic.
REQ-011 Port period, input, NUM_CH x CNT_W bits: per-channel terminal count in base ticks.
REQ-012 Port base_tick, output, 1 bit: one-cycle pulse once per base period.
REQ-013 Port tick, output, NUM_CH bits: per-channel one-cycle expiry pulse.
REQ-014 Port busy, output, NUM_CH bits: high while the channel is in RUN.

Function
REQ-015 The prescaler SHALL count 0..LIMIT, with LIMIT = BASE_DIV-1 (turbo low) or BASE_DIV/TURBO_DIV-1 (turbo high); both are elaboration-time constants.
REQ-016 The prescaler SHALL pulse base_tick, registered, for one cycle on the cycle after the count equals LIMIT, then SHALL restart from 0; the spacing SHALL be exactly LIMIT+1 cycles.
REQ-017 If turbo falls or rises mid-count and the count is already >= the new LIMIT, the prescaler SHALL wrap and pulse on the next cycle.
REQ-018 Each channel SHALL be a two-state FSM: IDLE and RUN.
REQ-019 In IDLE, start with period != 0 SHALL latch period and oneshot, clear the channel count, and enter RUN next cycle.
REQ-020 start with period == 0 SHALL be ignored, and the channel SHALL remain in or return to IDLE.
REQ-021 In RUN, each base_tick SHALL increment the channel count; when the count reaches the latched period, tick SHALL pulse for one cycle on the following cycle.
REQ-022 On expiry in periodic mode, the channel SHALL clear its count and stay in RUN; in one-shot mode it SHALL return to IDLE, with busy dropping in the same cycle as tick.
REQ-023 Changes to period or oneshot during RUN SHALL be ignored until the next start.
REQ-024 start in RUN SHALL restart the channel: clear the count, relatch period and mode, and emit no tick.
REQ-025 stop SHALL force IDLE next cycle and suppress any tick due in that cycle.
REQ-026 When start and stop are asserted together, stop SHALL win.
REQ-027 A start coinciding with base_tick SHALL not count that base_tick.
REQ-028 Channels SHALL be fully independent; simultaneous ticks on all channels are legal.
REQ-029 The channel counter SHALL be CNT_W bits wide and SHALL never wrap, because it is cleared at the terminal count.

Reset
REQ-030 While resetN is low, base_tick, tick and busy SHALL be 0, all counters 0, and all channels IDLE, asynchronously.
REQ-031 Reset mid-RUN SHALL abort the channel with no tick; after release the prescaler SHALL restart from 0 and the first base_tick SHALL occur LIMIT+1 cycles later.

Structure
REQ-032 Package tick_timer_pkg SHALL hold the channel state enum (IDLE, RUN) and default BASE_DIV, TURBO_DIV and CNT_W constants.
REQ-033 Sub-module tick_channel SHALL implement one channel FSM plus its counter, instantiated NUM_CH times by generate.
REQ-034 The prescaler SHALL be shared in the top level and SHALL have no divider logic in hardware.

Verification (BASE_DIV=20, TURBO_DIV=10, NUM_CH=4, CNT_W=8)
REQ-035 Free-run, turbo=0 -> base_tick every 20 cycles; turbo=1 -> every 2 cycles; turbo raised at count 15 -> base_tick next cycle.
REQ-036 Ch0 periodic, period=3, start -> busy next cycle, tick every 60 cycles, indefinitely.
REQ-037 Ch1 one-shot, period=2, start -> single tick about 40 cycles later, busy low with tick, no further ticks.
REQ-038 Ch2 start, then stop issued in the same cycle as the expected tick -> no tick, busy low next cycle; start+stop together -> stays IDLE.
REQ-039 Ch3 period=0 start -> stays IDLE; restart mid-RUN with period=5 -> next tick 5 base periods after restart.
REQ-040 resetN pulsed low during RUN on all channels -> all outputs 0 immediately; first base_tick 20 cycles after release.
